// File: rtl/parity2d_scan_codec_if.sv
// parity2d_scan_codec_if: command/data bus between the board inputs and the 2-D parity codec
interface parity2d_scan_codec_if #(
   parameter int ROWS = 4,
   parameter int COLS = 4
);
   localparam int N = ROWS * COLS;
   localparam int IDX_W = $clog2(N);
   logic [N-1:0]     data_in;
   logic             load;
   logic             inject;
   logic             check;
   logic [N-1:0]     data_out;
   logic             busy;
   logic             done;
   logic [1:0]       status;
   logic [IDX_W-1:0] err_index;
   logic [IDX_W-1:0] inj_index;
   modport master (
      output data_in, load, inject, check,
      input  data_out, busy, done, status, err_index, inj_index
   );
   modport slave (
      input  data_in, load, inject, check,
      output data_out, busy, done, status, err_index, inj_index
   );
endinterface

// File: rtl/parity2d_scan_codec.sv
// parity2d_scan_codec: ROWS x COLS block with stored row/column parity, LFSR error injection and a
// row-by-row scan that classifies errors. Optional single-bit repair: define PARITY2D_AUTOCORRECT_EN.
// Three or more flips can alias to SINGLE and be miscorrected; this is a known, accepted limit.
module parity2d_scan_codec #(
   parameter int          ROWS      = 4,
   parameter int          COLS      = 4,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input logic                  clk,
   input logic                  rst_n,
   parity2d_scan_codec_if.slave bus
);
   localparam int N = ROWS * COLS;
   localparam int IDX_W = $clog2(N);
   localparam int RW = $clog2(ROWS);
`ifdef PARITY2D_AUTOCORRECT_EN
   typedef enum logic [2:0] {IDLE, SCAN, EVAL, FIX, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SCAN, EVAL, DONE} state_t;
`endif
   state_t           state, state_n;
   logic [N-1:0]     data;
   logic [ROWS-1:0]  ref_row, rsyn, ld_row;
   logic [COLS-1:0]  ref_col, csyn, ld_col, row_cur;
   logic [RW-1:0]    r;
   logic [15:0]      lfsr;
   logic [1:0]       status, cls;
   logic [IDX_W-1:0] err_index, inj_index, inj_idx, loc_idx;
   logic             idle_load, idle_check, idle_inject, scan_last;
   int               a, b, r1, c1;

   assign idle_load   = state == IDLE && bus.load;
   assign idle_check  = state == IDLE && !bus.load && bus.check;
   assign idle_inject = state == IDLE && !bus.load && !bus.check && bus.inject;
   assign scan_last   = r == RW'(ROWS - 1);
   assign row_cur     = data[int'(r) * COLS +: COLS];
   assign inj_idx     = IDX_W'(lfsr % 16'(N));

   // Row and column parity of the block about to be loaded
   always_comb begin
      ld_row = '0;
      ld_col = '0;
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++) begin
            ld_row[i] = ld_row[i] ^ bus.data_in[i * COLS + j];
            ld_col[j] = ld_col[j] ^ bus.data_in[i * COLS + j];
         end
   end

   // Syndrome weights, located row/column and resulting class
   always_comb begin
      a  = 0;
      b  = 0;
      r1 = 0;
      c1 = 0;
      for (int i = 0; i < ROWS; i++)
         if (rsyn[i]) begin
            a  = a + 1;
            r1 = i;
         end
      for (int j = 0; j < COLS; j++)
         if (csyn[j]) begin
            b  = b + 1;
            c1 = j;
         end
      cls = (a == 0 && b == 0) ? 2'b00 :
            (a == 1 && b == 1) ? 2'b01 :
            ((a == 0) != (b == 0)) ? 2'b10 : 2'b11;
      loc_idx = IDX_W'(r1 * COLS + c1);
   end

   // Next-state logic: IDLE -> SCAN (ROWS cycles) -> EVAL -> [FIX] -> DONE -> IDLE
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: state_n = idle_check ? SCAN : IDLE;
         SCAN: state_n = scan_last ? EVAL : SCAN;
`ifdef PARITY2D_AUTOCORRECT_EN
         EVAL: state_n = cls == 2'b01 ? FIX : DONE;
         FIX:  state_n = DONE;
`else
         EVAL: state_n = DONE;
`endif
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_n;
   end

   // Free-running Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr <= LFSR_SEED;
      else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   // Block storage, reference parity, scan syndromes and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data      <= '0;
         ref_row   <= '0;
         ref_col   <= '0;
         rsyn      <= '0;
         csyn      <= '0;
         r         <= '0;
         status    <= '0;
         err_index <= '0;
         inj_index <= '0;
      end else begin
         if (idle_load) begin
            data      <= bus.data_in;
            ref_row   <= ld_row;
            ref_col   <= ld_col;
            status    <= '0;
            err_index <= '0;
         end
         if (idle_inject) begin
            data[inj_idx] <= ~data[inj_idx];
            inj_index     <= inj_idx;
         end
         if (idle_check) begin
            csyn <= ref_col;
            r    <= '0;
         end
         if (state == SCAN) begin
            rsyn[r] <= ^row_cur ^ ref_row[r];
            csyn    <= csyn ^ row_cur;
            r       <= r + 1'b1;
         end
         if (state == EVAL) begin
            status    <= cls;
            err_index <= cls == 2'b01 ? loc_idx : '0;
         end
`ifdef PARITY2D_AUTOCORRECT_EN
         if (state == FIX) data[err_index] <= ~data[err_index];
`endif
      end
   end

   assign bus.data_out  = data;
   assign bus.busy      = state != IDLE;
   assign bus.done      = state == DONE;
   assign bus.status    = status;
   assign bus.err_index = err_index;
   assign bus.inj_index = inj_index;
endmodule

// File: tb/tb_parity2d_scan_codec.sv
// tb_parity2d_scan_codec: scoreboard bench for a 4x4 and a 3x5 codec sharing clock and reset
module tb_parity2d_scan_codec;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   parity2d_scan_codec_if #(.ROWS(4), .COLS(4)) ia ();
   parity2d_scan_codec_if #(.ROWS(3), .COLS(5)) ib ();
   parity2d_scan_codec #(.ROWS(4), .COLS(4), .LFSR_SEED(16'hACE1)) ua (.clk(clk), .rst_n(rst_n), .bus(ia));
   parity2d_scan_codec #(.ROWS(3), .COLS(5), .LFSR_SEED(16'hACE1)) ub (.clk(clk), .rst_n(rst_n), .bus(ib));

   typedef struct {
      logic [1:0]  st;
      logic [15:0] ei;
      logic [15:0] dout;
      int          lat;
   } exp_t;
   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   logic [15:0] m_lfsr;
   logic [15:0] ref_d[2];
   logic [15:0] cur_d[2];

   // Reference LFSR, kept in step with both DUTs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   function automatic int nr(int s); return s != 0 ? 3 : 4; endfunction
   function automatic int nc(int s); return s != 0 ? 5 : 4; endfunction
   function automatic logic [15:0] g_dout(int s); return s != 0 ? {1'b0, ib.data_out} : ia.data_out; endfunction
   function automatic logic g_done(int s); return s != 0 ? ib.done : ia.done; endfunction
   function automatic logic g_busy(int s); return s != 0 ? ib.busy : ia.busy; endfunction
   function automatic logic [1:0] g_st(int s); return s != 0 ? ib.status : ia.status; endfunction
   function automatic logic [15:0] g_ei(int s); return s != 0 ? 16'(ib.err_index) : 16'(ia.err_index); endfunction
   function automatic logic [15:0] g_inj(int s); return s != 0 ? 16'(ib.inj_index) : 16'(ia.inj_index); endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(int s, logic ld, logic inj, logic chk, logic [15:0] din);
      if (s != 0) begin
         ib.load = ld; ib.inject = inj; ib.check = chk; ib.data_in = din[14:0];
      end else begin
         ia.load = ld; ia.inject = inj; ia.check = chk; ia.data_in = din;
      end
   endtask

   // Classify from the set of flipped bits relative to the loaded block
   task automatic calc(int s, output exp_t e);
      logic [15:0] d;
      logic [7:0]  rs, cs;
      int          r1, c1;
      d  = ref_d[s] ^ cur_d[s];
      rs = '0;
      cs = '0;
      r1 = 0;
      c1 = 0;
      for (int i = 0; i < nr(s); i++)
         for (int j = 0; j < nc(s); j++)
            if (d[i * nc(s) + j]) begin
               rs[i] = ~rs[i];
               cs[j] = ~cs[j];
            end
      for (int i = 0; i < 8; i++) if (rs[i]) r1 = i;
      for (int j = 0; j < 8; j++) if (cs[j]) c1 = j;
      e.st = ($countones(rs) == 0 && $countones(cs) == 0) ? 2'b00 :
             ($countones(rs) == 1 && $countones(cs) == 1) ? 2'b01 :
             (($countones(rs) == 0) != ($countones(cs) == 0)) ? 2'b10 : 2'b11;
      e.ei   = e.st == 2'b01 ? 16'(r1 * nc(s) + c1) : 16'h0;
      e.dout = cur_d[s];
      e.lat  = nr(s) + 2;
`ifdef PARITY2D_AUTOCORRECT_EN
      if (e.st == 2'b01) begin
         e.dout = cur_d[s] ^ (16'h1 << e.ei);
         e.lat  = e.lat + 1;
      end
`endif
   endtask

   task automatic do_load(int s, logic [15:0] v);
      logic [15:0] m;
      m = s != 0 ? 16'h7FFF : 16'hFFFF;
      drive(s, 1'b1, 1'b0, 1'b0, v);
      step;
      drive(s, 1'b0, 1'b0, 1'b0, v);
      ref_d[s] = v & m;
      cur_d[s] = v & m;
      tests++;
      if (g_dout(s) !== (v & m) || g_st(s) !== 2'b00 || g_ei(s) !== 16'h0 || g_busy(s) !== 1'b0) begin
         fails++;
         $display("FAIL load%0d: data_out=%h status=%b err=%0d busy=%b, required %h 00 0 0", s, g_dout(s), g_st(s), g_ei(s), g_busy(s), v & m);
      end
   endtask

   task automatic do_inject(int s, int target);
      logic [15:0] idx;
      bit          hit;
      hit = 1'b0;
      for (int k = 0; k < 3000 && !hit; k++)
         if (target < 0 || int'(m_lfsr % 16'(nr(s) * nc(s))) == target) hit = 1'b1;
         else step;
      tests++;
      if (!hit) begin
         fails++;
         $display("FAIL inject_wait%0d: index %0d never reached, required within 3000 cycles", s, target);
      end else begin
         idx = m_lfsr % 16'(nr(s) * nc(s));
         drive(s, 1'b0, 1'b1, 1'b0, 16'h0);
         step;
         drive(s, 1'b0, 1'b0, 1'b0, 16'h0);
         cur_d[s] = cur_d[s] ^ (16'h1 << idx);
         if (g_inj(s) !== idx || g_dout(s) !== cur_d[s]) begin
            fails++;
            $display("FAIL inject%0d: inj_index=%0d data_out=%h, required %0d %h", s, g_inj(s), g_dout(s), idx, cur_d[s]);
         end
      end
   endtask

   // Start a check, optionally firing load/inject during SCAN, then score the result at done
   task automatic do_check(int s, bit disturb);
      exp_t e, g;
      int   cnt;
      bit   got;
      calc(s, e);
      sb.push_back(e);
      drive(s, 1'b0, 1'b0, 1'b1, 16'h0);
      cnt = 0;
      got = 1'b0;
      while (cnt < 40 && !got) begin
         step;
         cnt++;
         drive(s, disturb && cnt == 1, disturb && cnt == 2, 1'b0, 16'hFFFF);
         if (g_done(s)) got = 1'b1;
      end
      drive(s, 1'b0, 1'b0, 1'b0, 16'h0);
      g = sb.pop_front();
      tests++;
      if (!got) begin
         fails++;
         $display("FAIL done_timeout%0d: no done in 40 cycles, required at %0d", s, g.lat);
      end else begin
         if (cnt != g.lat || g_st(s) !== g.st || g_ei(s) !== g.ei || g_dout(s) !== g.dout || g_busy(s) !== 1'b1) begin
            fails++;
            $display("FAIL check%0d: lat=%0d status=%b err=%0d data_out=%h busy=%b, required %0d %b %0d %h 1",
                     s, cnt, g_st(s), g_ei(s), g_dout(s), g_busy(s), g.lat, g.st, g.ei, g.dout);
         end
         cur_d[s] = g.dout;
         step;
         tests++;
         if (g_done(s) !== 1'b0 || g_busy(s) !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse%0d: done=%b busy=%b one cycle later, required 0 0", s, g_done(s), g_busy(s));
         end
      end
   endtask

   task automatic outputs_zero(string name);
      tests++;
      if (ia.data_out !== '0 || ia.busy !== 1'b0 || ia.done !== 1'b0 || ia.status !== '0 || ia.err_index !== '0 ||
          ia.inj_index !== '0 || ib.data_out !== '0 || ib.busy !== 1'b0 || ib.status !== '0 || ib.inj_index !== '0) begin
         fails++;
         $display("FAIL %s: a data=%h busy=%b done=%b st=%b err=%0d inj=%0d b data=%h, required all 0", name,
                  ia.data_out, ia.busy, ia.done, ia.status, ia.err_index, ia.inj_index, ib.data_out);
      end
   endtask

   task automatic test_reset;
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 16'h0);
      step;
      step;
      outputs_zero("reset");
      rst_n = 1'b1;
      for (int s = 0; s < 2; s++) begin
         ref_d[s] = 16'h0;
         cur_d[s] = 16'h0;
      end
      step;
   endtask

   task automatic test_clean;
      do_load(0, 16'hA5C3);
      do_check(0, 1'b0);
   endtask

   task automatic test_single;
      do_load(0, 16'hA5C3);
      do_inject(0, -1);
      do_check(0, 1'b0);
      tests++;
`ifdef PARITY2D_AUTOCORRECT_EN
      if (g_st(0) !== 2'b01 || g_ei(0) !== g_inj(0) || g_dout(0) !== 16'hA5C3) begin
`else
      if (g_st(0) !== 2'b01 || g_ei(0) !== g_inj(0) || g_dout(0) !== (16'hA5C3 ^ (16'h1 << g_inj(0)))) begin
`endif
         fails++;
         $display("FAIL single: status=%b err=%0d inj=%0d data_out=%h, required 01 err==inj", g_st(0), g_ei(0), g_inj(0), g_dout(0));
      end
   endtask

   task automatic test_line;
      do_load(0, 16'h0000);
      do_inject(0, 1);
      do_inject(0, 5);
      do_check(0, 1'b0);
      tests++;
      if (g_st(0) !== 2'b10 || g_dout(0) !== 16'h0022) begin
         fails++;
         $display("FAIL line: status=%b data_out=%h, required 10 0022", g_st(0), g_dout(0));
      end
   endtask

   task automatic test_multi;
      do_load(0, 16'hFFFF);
      do_inject(0, 0);
      do_inject(0, 5);
      do_check(0, 1'b0);
      tests++;
      if (g_st(0) !== 2'b11 || g_ei(0) !== 16'h0 || g_dout(0) !== 16'hFFDE) begin
         fails++;
         $display("FAIL multi: status=%b err=%0d data_out=%h, required 11 0 ffde", g_st(0), g_ei(0), g_dout(0));
      end
   endtask

   task automatic test_back_to_back;
      do_load(0, 16'hA5C3);
      do_check(0, 1'b1);
      do_check(0, 1'b0);
   endtask

   task automatic test_mid_reset;
      bit seen;
      do_load(0, 16'hA5C3);
      do_inject(0, -1);
      drive(0, 1'b0, 1'b0, 1'b1, 16'h0);
      step;
      drive(0, 1'b0, 1'b0, 1'b0, 16'h0);
      step;
      rst_n = 1'b0;
      #1;
      outputs_zero("mid_reset");
      step;
      rst_n = 1'b1;
      for (int s = 0; s < 2; s++) begin
         ref_d[s] = 16'h0;
         cur_d[s] = 16'h0;
      end
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step;
         if (ia.done) seen = 1'b1;
      end
      tests++;
      if (seen || ia.data_out !== 16'h0) begin
         fails++;
         $display("FAIL mid_reset_done: done seen=%b data_out=%h, required 0 0000", seen, ia.data_out);
      end
   endtask

   task automatic test_3x5;
      do_load(1, 16'h1234);
      do_check(1, 1'b0);
      do_inject(1, -1);
      do_check(1, 1'b0);
      tests++;
      if (g_st(1) !== 2'b01 || g_ei(1) !== g_inj(1) || g_ei(1) > 16'd14) begin
         fails++;
         $display("FAIL single_3x5: status=%b err=%0d inj=%0d, required 01 err==inj<15", g_st(1), g_ei(1), g_inj(1));
      end
   endtask

   initial begin
      test_reset;
      test_clean;
      test_single;
      test_line;
      test_multi;
      test_back_to_back;
      test_mid_reset;
      test_3x5;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/parity2d_scan_codec.md
Name: parity2d_scan_codec

Overview:
- Parametrised successor to the fixed 4x4 switch-parity inspector.
- Holds a ROWS x COLS data block and stores its row/column parity at load time.
- Injects pseudo-random single-bit errors on command, then runs a sequential row-by-row scan to locate and classify errors.
- Sits between board inputs (switch bank, push-button strobes) and the 7-seg/status display logic.

Parameters:
ROWS, 4, number of data rows (>=2)
COLS, 4, number of data columns (>=2); N=ROWS*COLS, IDX_W=clog2(N) derived locally
LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit injection LFSR

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  N  block to load; bit index = row*COLS+col
load  in  1  capture data_in and its parity (single-cycle strobe)
inject  in  1  flip one pseudo-random stored bit (strobe)
check  in  1  start scan/classify (strobe)
data_out  out  N  current stored block
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse when classification completes
status  out  2  00 CLEAN, 01 SINGLE, 10 LINE_ONLY, 11 MULTI
err_index  out  IDX_W  located bit for SINGLE, else 0
inj_index  out  IDX_W  index of the last injected bit

Behaviour:
- Reset: data_out, ref parity regs, status, err_index, inj_index, busy, done all 0; LFSR=LFSR_SEED; state IDLE.
- LFSR: Fibonacci, taps 16,14,13,11, advances every cycle regardless of state.
- IDLE command priority: load > check > inject. Commands arriving while busy are ignored, not queued.
- load: next edge stores data_in, ROWS row-parity bits (XOR of the row) and COLS column-parity bits; status, err_index cleared. Stays IDLE.
- inject: idx = LFSR mod N (full-width remainder); flips data_out[idx]; inj_index=idx. Parity regs untouched. Repeat injections accumulate; same index twice cancels.
- check: IDLE -> SCAN.
- SCAN: ROWS cycles with row counter r=0..ROWS-1. Each cycle: rsyn[r] = XOR(row r) ^ refrow[r]; csyn ^= row r. Column syndrome seeded with refcol at entry.
- SCAN -> EVAL after r=ROWS-1. EVAL (1 cycle): popcount of rsyn=a, of csyn=b.
  - a=0,b=0 -> CLEAN.
  - a=1,b=1 -> SINGLE; err_index=r1*COLS+c1.
  - exactly one of a,b zero -> LINE_ONLY.
  - otherwise -> MULTI.
- EVAL -> FIX if SINGLE and the feature is enabled, else DONE. FIX (1 cycle) flips data_out[err_index]. DONE: done=1 for one cycle -> IDLE.
- Latency check->done: ROWS+2 cycles (ROWS+3 with FIX). busy high from the cycle after check until done inclusive.
- status/err_index hold until the next load or completed check.
- Reset mid-operation: immediate return to reset values; no partial correction.
- Known limit: 3+ flips may alias to SINGLE (miscorrection). This is accepted and documented, not detected.

Optional Feature:
PARITY2D_AUTOCORRECT_EN
- Defined: SINGLE result passes through FIX and the located bit is restored in data_out.
- Undefined: FIX state absent; SINGLE is only reported; data_out unchanged by check.

Test Plan:
- Reset, load 16'hA5C3 (4x4), check -> done exactly 6 cycles later, status 00, err_index 0, data_out 16'hA5C3.
- Load 16'hA5C3, inject once, check -> status 01, err_index==inj_index; with macro data_out==16'hA5C3 after done (7 cycles), without macro data_out==16'hA5C3^(1<<inj_index).
- Load 16'h0000, force two injections in the same column (indices 1 and 5 via a chosen seed), check -> status 10, data_out unchanged.
- Load 16'hFFFF, two injections at indices 0 and 5, check -> status 11, err_index 0, no correction.
- Assert check, then load and inject during SCAN -> both ignored, data_out unchanged, done still at cycle 6; rst_n low at SCAN cycle 2 -> all outputs 0 at once, no done pulse.
- ROWS=3, COLS=5: load 15'h1234, inject, check -> done after 5 cycles (6 with macro), status 01, correct err_index in 0..14.
